// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed common-anode seven-segment driver with a sequential
// double-dabble binary-to-BCD converter and leading-zero blanking.
module seg_scan_driver #(
   parameter int SCAN_DIV = 50000,
   parameter int VAL_W    = 14
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [VAL_W-1:0] value,
   output logic             busy,
   output logic             ovf,
   output logic [3:0]       an,
   output logic [6:0]       seg
);

   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PW-1:0]    PRE_TC = PW'(SCAN_DIV - 1);
   localparam logic [VAL_W-1:0] MAXV   = VAL_W'(9999);
   localparam logic [3:0]       SH_LAST = 4'(VAL_W - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state, state_n;
   logic [VAL_W-1:0] bin;
   logic [15:0]      bcd;
   logic [11:0]      bcd_adj;
   logic [15:0]      disp;
   logic [3:0]       sh_cnt;
   logic [PW-1:0]    pre;
   logic [1:0]       idx;
   logic [3:0]       digit;
   logic             blank;
   logic [6:0]       seg_n;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (load) state_n = SHIFT;
         SHIFT:   if (sh_cnt == SH_LAST) state_n = DONE;
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

   // Top nibble never reaches 5 before the final shift for inputs <= 9999,
   // so only the lower three nibbles need the add-3 correction.
   always_comb begin
      bcd_adj = bcd[11:0];
      for (int unsigned i = 0; i < 3; i++) begin
         if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bin    <= '0;
         bcd    <= '0;
         sh_cnt <= '0;
         ovf    <= 1'b0;
         disp   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (load) begin
                  bin    <= (value > MAXV) ? MAXV : value;
                  ovf    <= (value > MAXV);
                  bcd    <= '0;
                  sh_cnt <= '0;
               end
            end
            SHIFT: begin
               bcd    <= {bcd[14:12], bcd_adj, bin[VAL_W-1]};
               bin    <= bin << 1;
               sh_cnt <= sh_cnt + 4'd1;
            end
            DONE:    disp <= bcd;
            default: ;
         endcase
      end
   end

   always_comb begin
      digit = disp[{idx, 2'b00} +: 4];
      blank = 1'b0;
      case (idx)
         2'd3: blank = (disp[15:12] == 4'd0);
         2'd2: blank = (disp[15:8] == 8'd0);
         2'd1: blank = (disp[15:4] == 12'd0);
         default: blank = 1'b0;
      endcase
      seg_n = 7'b1111111;
      if (!blank) begin
         case (digit)
            4'd0: seg_n = 7'b1000000;
            4'd1: seg_n = 7'b1111001;
            4'd2: seg_n = 7'b0100100;
            4'd3: seg_n = 7'b0110000;
            4'd4: seg_n = 7'b0011001;
            4'd5: seg_n = 7'b0010010;
            4'd6: seg_n = 7'b0000010;
            4'd7: seg_n = 7'b1111000;
            4'd8: seg_n = 7'b0000000;
            4'd9: seg_n = 7'b0010000;
            default: seg_n = 7'b1111111;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pre <= '0;
         idx <= '0;
         an  <= 4'b1111;
         seg <= 7'b1111111;
      end else begin
         if (pre == PRE_TC) begin
            pre <= '0;
            idx <= idx + 2'd1;
         end else begin
            pre <= pre + 1'b1;
         end
         an  <= ~(4'b0001 << idx);
         seg <= seg_n;
      end
   end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver: scan sequence, conversion handshake,
// overflow clamping, ignored loads, reset abort and SCAN_DIV=1 scanning.
module tb_seg_scan_driver;

   localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                          S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                          S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000,
                          S9 = 7'b0010000, SB = 7'b1111111;

   typedef struct {
      logic [13:0] v;
      logic        ovf;
      logic [6:0]  d3, d2, d1, d0;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst, load_a, load_b, sel;
   logic [13:0] value_a, value_b;
   logic        busy_a, busy_b, ovf_a, ovf_b;
   logic [3:0]  an_a, an_b, an_m;
   logic [6:0]  seg_a, seg_b, seg_m;
   int          total = 0;
   int          passed = 0;
   vec_t        tbl[9];

   always #5 clk = ~clk;

   seg_scan_driver #(.SCAN_DIV(4), .VAL_W(14)) dut_a (
      .clk(clk), .rst(rst), .load(load_a), .value(value_a),
      .busy(busy_a), .ovf(ovf_a), .an(an_a), .seg(seg_a));

   seg_scan_driver #(.SCAN_DIV(1), .VAL_W(14)) dut_b (
      .clk(clk), .rst(rst), .load(load_b), .value(value_b),
      .busy(busy_b), .ovf(ovf_b), .an(an_b), .seg(seg_b));

   assign an_m  = sel ? an_b  : an_a;
   assign seg_m = sel ? seg_b : seg_a;

   task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, got, exp);
   endtask

   // Collects the segment pattern shown under each anode over a full scan.
   task automatic capture(input string name, input logic [6:0] e3, e2, e1, e0);
      logic [6:0] got[4];
      logic [3:0] sel_an;
      for (int k = 0; k < 4; k++) got[k] = 'x;
      @(negedge clk);
      for (int c = 0; c < 17; c++) begin
         @(negedge clk);
         for (int k = 0; k < 4; k++) begin
            sel_an = ~(4'b0001 << k);
            if (an_m == sel_an) got[k] = seg_m;
         end
      end
      chk({name, " d3"}, 16'(got[3]), 16'(e3));
      chk({name, " d2"}, 16'(got[2]), 16'(e2));
      chk({name, " d1"}, 16'(got[1]), 16'(e1));
      chk({name, " d0"}, 16'(got[0]), 16'(e0));
   endtask

   // Loads dut_a and checks ovf at N+1, busy over N+1..N+15 and low at N+16.
   task automatic load_a_track(input string name, input logic [13:0] v, input logic exp_ovf);
      int hi;
      @(negedge clk); load_a = 1'b1; value_a = v;
      @(negedge clk); load_a = 1'b0;
      chk({name, " ovf"}, 16'(ovf_a), 16'(exp_ovf));
      hi = int'(busy_a);
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         hi += int'(busy_a);
      end
      chk({name, " busy cycles"}, 16'(hi), 16'd15);
      @(negedge clk);
      chk({name, " busy low N+16"}, 16'(busy_a), 16'd0);
   endtask

   initial begin
      tbl[0] = '{14'd1234,  1'b0, S1, S2, S3, S4};
      tbl[1] = '{14'h3FFF,  1'b1, S9, S9, S9, S9};
      tbl[2] = '{14'd7,     1'b0, SB, SB, SB, S7};
      tbl[3] = '{14'd0,     1'b0, SB, SB, SB, S0};
      tbl[4] = '{14'd9999,  1'b0, S9, S9, S9, S9};
      tbl[5] = '{14'd1000,  1'b0, S1, S0, S0, S0};
      tbl[6] = '{14'd909,   1'b0, SB, S9, S0, S9};
      tbl[7] = '{14'd5678,  1'b0, S5, S6, S7, S8};
      tbl[8] = '{14'd10000, 1'b1, S9, S9, S9, S9};

      rst = 1'b1; load_a = 1'b0; load_b = 1'b0; value_a = '0; value_b = '0; sel = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk); rst = 1'b0;

      for (int i = 0; i < 32; i++) begin
         logic [3:0] exp_an;
         int d;
         @(negedge clk);
         d = (i / 4) % 4;
         exp_an = ~(4'b0001 << d);
         chk($sformatf("reset scan an c%0d", i), 16'(an_a), 16'(exp_an));
         chk($sformatf("reset scan seg c%0d", i), 16'(seg_a), 16'((d == 0) ? S0 : SB));
      end
      chk("reset busy", 16'(busy_a), 16'd0);
      chk("reset ovf", 16'(ovf_a), 16'd0);

      for (int t = 0; t < 9; t++) begin
         load_a_track($sformatf("vec%0d", t), tbl[t].v, tbl[t].ovf);
         capture($sformatf("vec%0d", t), tbl[t].d3, tbl[t].d2, tbl[t].d1, tbl[t].d0);
      end

      begin : ignored_load
         int hi;
         @(negedge clk); load_a = 1'b1; value_a = 14'd50;
         @(negedge clk); value_a = 14'd999;
         hi = int'(busy_a);
         for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            hi += int'(busy_a);
         end
         chk("ign busy cycles", 16'(hi), 16'd15);
         @(negedge clk); load_a = 1'b0;
         chk("ign busy low", 16'(busy_a), 16'd0);
         chk("ign ovf cleared", 16'(ovf_a), 16'd0);
         capture("ign 50", SB, SB, S5, S0);
         load_a_track("after ign", 14'd999, 1'b0);
         capture("after ign 999", SB, S9, S9, S9);
      end

      @(negedge clk); load_a = 1'b1; value_a = 14'd4321;
      @(negedge clk); load_a = 1'b0;
      repeat (6) @(negedge clk);
      @(negedge clk); rst = 1'b1;
      @(negedge clk);
      chk("abort busy", 16'(busy_a), 16'd0);
      chk("abort an", 16'(an_a), 16'hF);
      chk("abort seg", 16'(seg_a), 16'h7F);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      capture("abort disp", SB, SB, SB, S0);
      chk("abort ovf", 16'(ovf_a), 16'd0);

      sel = 1'b1;
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         logic [3:0] exp_an;
         @(negedge clk);
         exp_an = ~(4'b0001 << (i % 4));
         chk($sformatf("div1 an c%0d", i), 16'(an_b), 16'(exp_an));
      end
      @(negedge clk); load_b = 1'b1; value_b = 14'd8008;
      @(negedge clk); load_b = 1'b0;
      begin : wait_b
         int w = 0;
         while (busy_b && w < 40) begin
            @(negedge clk);
            w++;
         end
         chk("div1 busy timeout", 16'(busy_b), 16'd0);
      end
      capture("div1 8008", S8, S0, S0, S8);
      chk("div1 ovf", 16'(ovf_b), 16'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
